// File: rtl/rps_pkg.sv
// Shared constants and types for the rock-paper-scissors front-end and checker.
// The move words use the same right-aligned packing as a Verilog string literal.
package rps_pkg;

   localparam int          MAX_CHARS_DEF = 8;
   localparam logic [7:0]  DELIM_DEF     = 8'h0D;

   localparam logic [7:0]  ASCII_SP      = 8'h20;
   localparam logic [7:0]  ASCII_TILDE   = 8'h7E;
   localparam logic [7:0]  ASCII_LC_A    = 8'h61;
   localparam logic [7:0]  ASCII_LC_Z    = 8'h7A;
   localparam logic [7:0]  ASCII_CASE    = 8'h20;

   localparam logic [63:0] NAME_ROCK     = 64'h0000_0000_524F_434B;
   localparam logic [63:0] NAME_PAPER    = 64'h0000_0050_4150_4552;
   localparam logic [63:0] NAME_SCISSORS = 64'h5343_4953_534F_5253;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_HOLD    = 2'd2,
      S_DROP    = 2'd3
   } state_t;

   function automatic logic [7:0] to_upper(input logic [7:0] c);
      if ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z))
         return c - ASCII_CASE;
      return c;
   endfunction

endpackage

// File: rtl/rps_char_filter.sv
// Classifies one incoming byte as delimiter / printable / other and
// produces the uppercased character that would be stored.
module rps_char_filter
   import rps_pkg::*;
#(
   parameter logic [7:0] DELIM = DELIM_DEF
) (
   input  logic [7:0] i_data,
   output logic       o_is_delim,
   output logic       o_is_print,
   output logic [7:0] o_char
);

   assign o_is_delim = (i_data == DELIM);
   assign o_is_print = (i_data >= ASCII_SP) && (i_data <= ASCII_TILDE);
   assign o_char     = to_upper(i_data);

endmodule

// File: rtl/rps_name_packer.sv
// Packs an ASCII byte stream into a right-aligned name word and presents it
// with a valid/ack handshake on each delimiter; overlong words are dropped.
module rps_name_packer
   import rps_pkg::*;
#(
   parameter int         MAX_CHARS = MAX_CHARS_DEF,
   parameter int         NAME_W    = 8 * MAX_CHARS,
   parameter logic [7:0] DELIM     = DELIM_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [NAME_W-1:0] name,
   output logic              name_valid,
   input  logic              name_ack,
   output logic [3:0]        char_cnt,
   output logic              err_ovf
);

   state_t            r_state;
   logic [NAME_W-1:0] r_name;
   logic [3:0]        r_char_cnt;
   logic              r_name_valid;
   logic              r_err_ovf;

   logic              w_is_delim;
   logic              w_is_print;
   logic [7:0]        w_char;
   logic              w_xfer;
   logic [NAME_W-1:0] w_name_shift;
   logic              w_full;

   rps_char_filter #(
      .DELIM(DELIM)
   ) u_filter (
      .i_data    (in_data),
      .o_is_delim(w_is_delim),
      .o_is_print(w_is_print),
      .o_char    (w_char)
   );

   assign in_ready     = (r_state != S_HOLD);
   assign w_xfer       = in_valid && in_ready;
   assign w_name_shift = {r_name[NAME_W-9:0], w_char};
   assign w_full       = (r_char_cnt == 4'(MAX_CHARS));

   // Delimiter is tested before printable so a printable DELIM still terminates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_name       <= '0;
         r_char_cnt   <= '0;
         r_name_valid <= 1'b0;
         r_err_ovf    <= 1'b0;
      end else begin
         r_err_ovf <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_xfer && !w_is_delim && w_is_print) begin
                  r_name     <= w_name_shift;
                  r_char_cnt <= 4'd1;
                  r_state    <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (w_xfer) begin
                  if (w_is_delim) begin
                     r_name_valid <= 1'b1;
                     r_state      <= S_HOLD;
                  end else if (w_is_print) begin
                     if (w_full) begin
                        r_err_ovf  <= 1'b1;
                        r_name     <= '0;
                        r_char_cnt <= '0;
                        r_state    <= S_DROP;
                     end else begin
                        r_name     <= w_name_shift;
                        r_char_cnt <= r_char_cnt + 4'd1;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (name_ack) begin
                  r_name_valid <= 1'b0;
                  r_name       <= '0;
                  r_char_cnt   <= '0;
                  r_state      <= S_IDLE;
               end
            end
            S_DROP: begin
               if (w_xfer && w_is_delim)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign name       = r_name;
   assign char_cnt   = r_char_cnt;
   assign name_valid = r_name_valid;
   assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_rps_name_packer.sv
// Directed bench for rps_name_packer: packing, case folding, overflow,
// backpressure, control-byte filtering and asynchronous reset.
module tb_rps_name_packer;

   localparam logic [63:0] EXP_ROCK     = 64'h0000_0000_524F_434B;
   localparam logic [63:0] EXP_PAPER    = 64'h0000_0050_4150_4552;
   localparam logic [63:0] EXP_SCISSORS = 64'h5343_4953_534F_5253;
   localparam logic [7:0]  CR           = 8'h0D;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] name;
   logic        name_valid;
   logic        name_ack;
   logic [3:0]  char_cnt;
   logic        err_ovf;

   int n_checks;
   int n_fail;
   int ovf_seen;

   rps_name_packer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .name      (name),
      .name_valid(name_valid),
      .name_ack  (name_ack),
      .char_cnt  (char_cnt),
      .err_ovf   (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (err_ovf) ovf_seen++;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
      if (err_ovf) ovf_seen++;
   endtask

   task automatic do_ack();
      name_ack = 1'b1;
      @(posedge clk);
      #1;
      name_ack = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (name !== 64'h0) begin n_fail++; $display("FAIL reset_name got %h want %h", name, 64'h0); end
      n_checks++;
      if (char_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", char_cnt); end
      n_checks++;
      if (name_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", name_valid); end
      n_checks++;
      if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", err_ovf); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
   endtask

   task automatic test_rock();
      send_str("ROCK");
      send_byte(CR);
      n_checks++;
      if (name !== EXP_ROCK) begin n_fail++; $display("FAIL rock_name got %h want %h", name, EXP_ROCK); end
      n_checks++;
      if (name_valid !== 1'b1) begin n_fail++; $display("FAIL rock_valid got %b want 1", name_valid); end
      n_checks++;
      if (char_cnt !== 4'd4) begin n_fail++; $display("FAIL rock_cnt got %0d want 4", char_cnt); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rock_ready got %b want 0", in_ready); end
      do_ack();
      n_checks++;
      if (name !== 64'h0) begin n_fail++; $display("FAIL rock_ack_name got %h want 0", name); end
      n_checks++;
      if (name_valid !== 1'b0) begin n_fail++; $display("FAIL rock_ack_valid got %b want 0", name_valid); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rock_ack_ready got %b want 1", in_ready); end
      n_checks++;
      if (char_cnt !== 4'd0) begin n_fail++; $display("FAIL rock_ack_cnt got %0d want 0", char_cnt); end
   endtask

   task automatic test_paper_lowercase();
      send_str("paper");
      send_byte(CR);
      n_checks++;
      if (name !== EXP_PAPER) begin n_fail++; $display("FAIL paper_name got %h want %h", name, EXP_PAPER); end
      n_checks++;
      if (char_cnt !== 4'd5) begin n_fail++; $display("FAIL paper_cnt got %0d want 5", char_cnt); end
      n_checks++;
      if (name_valid !== 1'b1) begin n_fail++; $display("FAIL paper_valid got %b want 1", name_valid); end
      do_ack();
   endtask

   task automatic test_full_word();
      ovf_seen = 0;
      send_str("SCISSORS");
      send_byte(CR);
      n_checks++;
      if (name !== EXP_SCISSORS) begin n_fail++; $display("FAIL scissors_name got %h want %h", name, EXP_SCISSORS); end
      n_checks++;
      if (char_cnt !== 4'd8) begin n_fail++; $display("FAIL scissors_cnt got %0d want 8", char_cnt); end
      n_checks++;
      if (ovf_seen !== 0) begin n_fail++; $display("FAIL scissors_ovf got %0d pulses want 0", ovf_seen); end
      n_checks++;
      if (name_valid !== 1'b1) begin n_fail++; $display("FAIL scissors_valid got %b want 1", name_valid); end
      do_ack();
   endtask

   task automatic test_overflow();
      ovf_seen = 0;
      send_str("SCISSORS");
      n_checks++;
      if (ovf_seen !== 0) begin n_fail++; $display("FAIL ovf_early got %0d pulses want 0", ovf_seen); end
      send_byte("X");
      n_checks++;
      if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", err_ovf); end
      n_checks++;
      if (name !== 64'h0) begin n_fail++; $display("FAIL ovf_name got %h want 0", name); end
      n_checks++;
      if (char_cnt !== 4'd0) begin n_fail++; $display("FAIL ovf_cnt got %0d want 0", char_cnt); end
      idle_cycle();
      n_checks++;
      if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_width got %b want 0", err_ovf); end
      send_str("AB");
      n_checks++;
      if (char_cnt !== 4'd0) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d want 0", char_cnt); end
      send_byte(CR);
      n_checks++;
      if (name_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_no_valid got %b want 0", name_valid); end
      n_checks++;
      if (ovf_seen !== 1) begin n_fail++; $display("FAIL ovf_count got %0d pulses want 1", ovf_seen); end
      send_str("ROCK");
      send_byte(CR);
      n_checks++;
      if (name !== EXP_ROCK) begin n_fail++; $display("FAIL ovf_recover_name got %h want %h", name, EXP_ROCK); end
      n_checks++;
      if (name_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_recover_valid got %b want 1", name_valid); end
      do_ack();
   endtask

   task automatic test_backpressure();
      send_str("PAPER");
      send_byte(CR);
      in_data  = "P";
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
         n_checks++;
         if (name !== EXP_PAPER) begin n_fail++; $display("FAIL bp_name[%0d] got %h want %h", i, name, EXP_PAPER); end
      end
      name_ack = 1'b1;
      @(posedge clk);
      #1;
      name_ack = 1'b0;
      n_checks++;
      if (name !== 64'h0) begin n_fail++; $display("FAIL bp_ack_name got %h want 0", name); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ack_ready got %b want 1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if (char_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_p_cnt got %0d want 1", char_cnt); end
      n_checks++;
      if (name !== 64'h50) begin n_fail++; $display("FAIL bp_p_name got %h want %h", name, 64'h50); end
      idle_cycle();
      n_checks++;
      if (char_cnt !== 4'd1) begin n_fail++; $display("FAIL bp_p_once got %0d want 1", char_cnt); end
      send_byte(CR);
      do_ack();
   endtask

   task automatic test_misc();
      send_byte(CR);
      n_checks++;
      if (name_valid !== 1'b0) begin n_fail++; $display("FAIL lone_cr_valid got %b want 0", name_valid); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lone_cr_ready got %b want 1", in_ready); end
      name_ack = 1'b1;
      send_str("RO");
      name_ack = 1'b0;
      n_checks++;
      if (char_cnt !== 4'd2) begin n_fail++; $display("FAIL ro_cnt got %0d want 2", char_cnt); end
      send_byte(8'h07);
      n_checks++;
      if (char_cnt !== 4'd2) begin n_fail++; $display("FAIL ctrl_cnt got %0d want 2", char_cnt); end
      n_checks++;
      if (name !== 64'h524F) begin n_fail++; $display("FAIL ctrl_name got %h want %h", name, 64'h524F); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (name !== 64'h0) begin n_fail++; $display("FAIL async_rst_name got %h want 0", name); end
      n_checks++;
      if (char_cnt !== 4'd0) begin n_fail++; $display("FAIL async_rst_cnt got %0d want 0", char_cnt); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready got %b want 1", in_ready); end
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_str("ROCK");
      send_byte(CR);
      n_checks++;
      if (name !== EXP_ROCK) begin n_fail++; $display("FAIL post_rst_name got %h want %h", name, EXP_ROCK); end
      n_checks++;
      if (char_cnt !== 4'd4) begin n_fail++; $display("FAIL post_rst_cnt got %0d want 4", char_cnt); end
      do_ack();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      ovf_seen = 0;
      rst      = 1'b1;
      in_data  = 8'h00;
      in_valid = 1'b0;
      name_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_rock();
      test_paper_lowercase();
      test_full_word();
      test_overflow();
      test_backpressure();
      test_misc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rps_name_packer.md
# rps_name_packer

Upstream front-end for the rock-paper-scissors move checker. Accepts an ASCII byte stream one character per transfer and packs it into a right-aligned 64-bit name word, the same packing a Verilog string literal uses: "ROCK" = 64'h0000_0000_524F_434B. On a delimiter it presents the completed word with a valid/ack handshake. The downstream checker consumes `name` directly and uses `name_valid` as its enable.

## Interface
- `MAX_CHARS`, default 8: maximum stored characters.
- `NAME_W`, default 8*MAX_CHARS: name word width.
- `DELIM`, default 8'h0D: terminator byte (carriage return).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  ASCII byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `name`  out  NAME_W  packed word, last character in bits [7:0].
- `name_valid`  out  1  `name` is complete and stable.
- `name_ack`  in  1  consumer has taken `name`.
- `char_cnt`  out  4  characters currently stored, 0..MAX_CHARS.
- `err_ovf`  out  1  one-cycle pulse when a word exceeds MAX_CHARS.

## Operation
- **Transfer rule:** a byte transfers when `in_valid && in_ready`. Non-transferred bytes have no effect.
- **Byte classes:**
  - DELIM.
  - Printable (8'h20–8'h7E): lowercase 'a'–'z' is uppercased (minus 8'h20) before storage.
  - Other: control bytes other than DELIM are silently dropped and not counted.
- **Storing a printable byte:** `name <= {name[NAME_W-9:0], char}` and `char_cnt` increments.
- **FSM states:**
  - IDLE
    - `char_cnt`=0, `in_ready`=1.
    - Printable byte → store it, go to COLLECT.
    - DELIM → ignored; stay in IDLE, no output.
  - COLLECT
    - `in_ready`=1.
    - Printable byte with `char_cnt` < MAX_CHARS → store.
    - Printable byte with `char_cnt` == MAX_CHARS → pulse `err_ovf`, clear `name` and `char_cnt`, go to DROP.
    - DELIM → go to HOLD.
  - HOLD
    - `name_valid`=1, `in_ready`=0.
    - `name` and `char_cnt` are frozen.
    - `name_ack` → clear `name` and `char_cnt`, go to IDLE.
  - DROP
    - `in_ready`=1.
    - All bytes are discarded.
    - DELIM → go to IDLE.
    - No `name_valid` is produced for the overflowed word.
- `name_ack` outside HOLD is ignored.
- **Reset (asynchronous, at any time, including mid-word or during HOLD):**
  - State goes to IDLE.
  - `name`=0, `char_cnt`=0, `name_valid`=0, `err_ovf`=0.
  - `in_ready` is 1 while in IDLE after reset.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- DELIM accepted in cycle N → `name_valid`=1 and `in_ready`=0 from cycle N+1.
- `name_ack` sampled high in cycle M (in HOLD) → `name_valid`=0, `name`=0 and `in_ready`=1 from cycle M+1.
  - Minimum turnaround from DELIM to next accepted byte is 2 cycles, with `name_ack` tied high.
- Overflow byte accepted in cycle N → `err_ovf`=1 in cycle N+1 only.
- Throughput: one character per cycle while collecting.

## Structure
- **Package `rps_pkg`:**
  - `MAX_CHARS` and `DELIM` defaults.
  - ASCII constants: 8'h20, 8'h7E, 'a', 'z'.
  - Move-name constants ROCK/PAPER/SCISSORS as 64-bit words, shared with the checker and the bench.
  - FSM state enum {IDLE, COLLECT, HOLD, DROP}.
- **Sub-module `rps_char_filter`** (combinational):
  - Input: `in_data`.
  - Outputs: `is_delim`, `is_print`, uppercased `char`.
- The top level holds the FSM, shift register and counter. Target size is about 150–250 lines.

## Test plan
- "ROCK" then 8'h0D, back-to-back → one cycle after the DELIM: `name`=64'h0000_0000_524F_434B, `name_valid`=1, `char_cnt`=4; `name_ack` clears `name` to 0 the next cycle.
- "paper" then 8'h0D → `name`=64'h0000_0050_4150_4552 ("PAPER"), `char_cnt`=5.
- "SCISSORS" then 8'h0D (exactly 8 characters) → `name`=64'h5343_4953_534F_5253, no `err_ovf`.
- "SCISSORSX" then 8'h0D → `err_ovf` pulses once, in the cycle after 'X'; no `name_valid`. A following "ROCK" then 8'h0D produces the correct word.
- Backpressure:
  - Hold `name_ack`=0 for 10 cycles in HOLD with `in_valid`=1, `in_data`='P' → `in_ready`=0 and `name` stable throughout.
  - After ack, 'P' is accepted exactly once.
- Lone 8'h0D, control byte 8'h07 mid-word, and `rst` asserted after "RO" →
  - Lone 8'h0D: no `name_valid`.
  - 8'h07: dropped, `char_cnt` unchanged.
  - `rst`: `name`=0 and `char_cnt`=0 immediately, without waiting for a clock edge.
